// File: rtl/m_receiver.sv
`timescale 1ns/1ps
// m_receiver: Manchester line receiver - preamble lock, SFD detect, LSB-first byte stream, frame status.
// Optional CRC-8 frame check (poly 0x07, residue must be zero) enabled by defining M_RECEIVER_CRC8_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | line quiet; first rising edge is taken as the mid-bit of a 1
// PREAMBLE | counting alternating bits; a 1,1 pair after enough of them is the SFD
// DATA     | shifting payload bits in, emitting bytes, closing on silence
// GAP      | after an abort or lost lock, wait 2*OVERSAMPLE edge-free cycles
module m_receiver #(
    parameter int OVERSAMPLE      = 8,
    parameter int PREAMBLE_MIN    = 16,
    parameter int MAX_FRAME_BYTES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_frame_err,
    output logic [7:0] o_frames_count,
    output logic [7:0] o_status,
    output logic       o_busy
);
    localparam int CW  = $clog2(2 * OVERSAMPLE) + 1;
    localparam int BCW = $clog2(MAX_FRAME_BYTES + 2);

    localparam logic [CW-1:0]  T_VIOL    = CW'(OVERSAMPLE / 4);
    localparam logic [CW-1:0]  T_MID_LO  = CW'(3 * OVERSAMPLE / 4);
    localparam logic [CW-1:0]  T_MID_HI  = CW'(5 * OVERSAMPLE / 4);
    localparam logic [CW-1:0]  T_SIL     = CW'(3 * OVERSAMPLE / 2);
    localparam logic [CW-1:0]  T_GAP     = CW'(2 * OVERSAMPLE - 1);
    localparam logic [BCW-1:0] MAX_BYTES = BCW'(MAX_FRAME_BYTES);
    localparam logic [7:0]     PRE_MIN   = 8'(PREAMBLE_MIN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic [7:0]     pre_cnt_q, pre_cnt_d;
    logic           last_bit_q, last_bit_d;
    logic           bnd_seen_q, bnd_seen_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]     data_q, data_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_end_q, frame_end_d;
    logic           frame_err_q, frame_err_d;
    logic [7:0]     frames_count_q, frames_count_d;
    logic [5:0]     status_q, status_d;

    logic       rx_edge, silence, mid_edge, bnd_edge, violation;
    logic [7:0] byte_w;

`ifdef M_RECEIVER_CRC8_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int k = 0; k < 8; k++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Edge classification relative to the last accepted mid-bit edge.
    always_comb begin
        rx_edge   = rx_sync_q ^ rx_prev_q;
        silence   = cnt_q >= T_SIL;
        mid_edge  = rx_edge && !silence && (cnt_q >= T_MID_LO) && (cnt_q <= T_MID_HI);
        bnd_edge  = rx_edge && !bnd_seen_q && (cnt_q >= T_VIOL) && (cnt_q < T_MID_LO);
        violation = rx_edge && !silence && !mid_edge && !bnd_edge;
        byte_w    = {rx_sync_q, shift_q[7:1]};
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = (cnt_q < T_SIL) ? cnt_q + 1'b1 : cnt_q;
        gap_d          = gap_q;
        pre_cnt_d      = pre_cnt_q;
        last_bit_d     = last_bit_q;
        bnd_seen_d     = bnd_seen_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        data_d         = data_q;
        data_valid_d   = 1'b0;
        frame_start_d  = 1'b0;
        frame_end_d    = 1'b0;
        frame_err_d    = 1'b0;
        frames_count_d = frames_count_q;
        status_d       = status_q;
`ifdef M_RECEIVER_CRC8_EN
        crc_d          = crc_q;
`endif

        if (mid_edge) begin
            cnt_d      = '0;
            bnd_seen_d = 1'b0;
            last_bit_d = rx_sync_q;
        end
        if (bnd_edge) begin
            bnd_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                bnd_seen_d = 1'b0;
                if (rx_edge && rx_sync_q) begin
                    state_d    = S_PREAMBLE;
                    pre_cnt_d  = 8'd1;
                    last_bit_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (silence || violation) begin
                    state_d = S_GAP;
                    gap_d   = T_GAP;
                end else if (mid_edge) begin
                    if (rx_sync_q != last_bit_q) begin
                        pre_cnt_d = (pre_cnt_q == 8'hFF) ? pre_cnt_q : pre_cnt_q + 8'd1;
                    end else if (rx_sync_q && (pre_cnt_q >= PRE_MIN)) begin
                        state_d       = S_DATA;
                        frame_start_d = 1'b1;
                        bit_cnt_d     = 3'd0;
                        byte_cnt_d    = '0;
                        shift_d       = 8'h00;
`ifdef M_RECEIVER_CRC8_EN
                        crc_d         = 8'h00;
`endif
                    end else begin
                        pre_cnt_d = 8'd1;
                    end
                end
            end
            S_DATA: begin
                if (silence) begin
                    state_d     = S_IDLE;
                    frame_end_d = 1'b1;
                    if (bit_cnt_q != 3'd0) begin
                        frame_err_d = 1'b1;
                        status_d[1] = 1'b1;
                    end else if (byte_cnt_q == '0) begin
                        frame_err_d = 1'b1;
                        status_d[2] = 1'b1;
`ifdef M_RECEIVER_CRC8_EN
                    end else if (crc_q != 8'h00) begin
                        frame_err_d = 1'b1;
                        status_d[5] = 1'b1;
`endif
                    end else begin
                        frames_count_d = frames_count_q + 8'd1;
                    end
                end else if (violation) begin
                    state_d     = S_GAP;
                    gap_d       = T_GAP;
                    frame_end_d = 1'b1;
                    frame_err_d = 1'b1;
                    status_d[3] = 1'b1;
                end else if (mid_edge) begin
                    shift_d   = byte_w;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // The byte that would exceed the limit aborts the frame and is dropped.
                        if (byte_cnt_q == MAX_BYTES) begin
                            state_d     = S_GAP;
                            gap_d       = T_GAP;
                            frame_end_d = 1'b1;
                            frame_err_d = 1'b1;
                            status_d[4] = 1'b1;
                        end else begin
                            data_d       = byte_w;
                            data_valid_d = 1'b1;
                            byte_cnt_d   = byte_cnt_q + 1'b1;
`ifdef M_RECEIVER_CRC8_EN
                            crc_d        = crc8_step(crc_q, byte_w);
`endif
                        end
                    end
                end
            end
            S_GAP: begin
                if (rx_edge) begin
                    gap_d = T_GAP;
                end else if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                status_d[0] = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            rx_meta_q      <= 1'b0;
            rx_sync_q      <= 1'b0;
            rx_prev_q      <= 1'b0;
            cnt_q          <= '0;
            gap_q          <= '0;
            pre_cnt_q      <= 8'd0;
            last_bit_q     <= 1'b0;
            bnd_seen_q     <= 1'b0;
            shift_q        <= 8'h00;
            bit_cnt_q      <= 3'd0;
            byte_cnt_q     <= '0;
            data_q         <= 8'h00;
            data_valid_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_end_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            frames_count_q <= 8'd0;
            status_q       <= 6'd0;
`ifdef M_RECEIVER_CRC8_EN
            crc_q          <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            rx_meta_q      <= i_rx;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            cnt_q          <= cnt_d;
            gap_q          <= gap_d;
            pre_cnt_q      <= pre_cnt_d;
            last_bit_q     <= last_bit_d;
            bnd_seen_q     <= bnd_seen_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            frame_start_q  <= frame_start_d;
            frame_end_q    <= frame_end_d;
            frame_err_q    <= frame_err_d;
            frames_count_q <= frames_count_d;
            status_q       <= status_d;
`ifdef M_RECEIVER_CRC8_EN
            crc_q          <= crc_d;
`endif
        end
    end

    assign o_data         = data_q;
    assign o_data_valid   = data_valid_q;
    assign o_frame_start  = frame_start_q;
    assign o_frame_end    = frame_end_q;
    assign o_frame_err    = frame_err_q;
    assign o_frames_count = frames_count_q;
    assign o_status       = {1'b0, state_q == S_DATA, status_q};
    assign o_busy         = state_q != S_IDLE;

endmodule

// File: tb/tb_m_receiver.sv
`timescale 1ns/1ps
// Scoreboard bench for m_receiver: frame-level reference model pushes expected events,
// a monitor pops them as the receiver strobes. CRC expectations follow M_RECEIVER_CRC8_EN.
module tb_m_receiver;
    localparam int B     = 8;
    localparam int PMIN  = 16;
    localparam int MAXB  = 255;
    localparam int T     = 10;
    localparam int EV_START = 0;
    localparam int EV_DATA  = 1;
    localparam int EV_END   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_frame_start;
    logic       o_frame_end;
    logic       o_frame_err;
    logic [7:0] o_frames_count;
    logic [7:0] o_status;
    logic       o_busy;

    always #(T / 2) clk = ~clk;

    m_receiver #(
        .OVERSAMPLE      (B),
        .PREAMBLE_MIN    (PMIN),
        .MAX_FRAME_BYTES (MAXB)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx           (rx),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_frame_start  (o_frame_start),
        .o_frame_end    (o_frame_end),
        .o_frame_err    (o_frame_err),
        .o_frames_count (o_frames_count),
        .o_status       (o_status),
        .o_busy         (o_busy)
    );

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       err;
        logic [5:0] sticky;
        logic [7:0] count;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_count = 0;
    logic [5:0] exp_sticky = 6'd0;
    logic [7:0] exp_last = 8'h00;
    time        last_mid_t = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic push_ev(input int kind, input logic [7:0] d, input logic e);
        ev_t ev;
        ev.kind   = kind;
        ev.data   = d;
        ev.err    = e;
        ev.sticky = exp_sticky;
        ev.count  = exp_count[7:0];
        exp_q.push_back(ev);
    endtask

    task automatic end_ev(input logic e, input logic [5:0] flag);
        exp_sticky = exp_sticky | flag;
        if (!e) exp_count = (exp_count + 1) % 256;
        push_ev(EV_END, 8'h00, e);
    endtask

    // Frame-level model: what the receiver must report for this frame.
    task automatic model_frame(input int npre, input int nbits, input int g);
        int         nfull;
        logic [7:0] crc;
        if (npre + 7 < PMIN) return;
        push_ev(EV_START, 8'h00, 1'b0);
        nfull = (g >= 0) ? (g + 1) / 8 : nbits / 8;
        for (int i = 0; i < nfull && i < MAXB; i++) begin
            push_ev(EV_DATA, fb[i], 1'b0);
            exp_last = fb[i];
        end
        crc = 8'h00;
        for (int i = 0; i < nfull && i < MAXB; i++) crc = crc8(crc, fb[i]);
        if (g >= 0)                end_ev(1'b1, 6'h08);
        else if (nfull > MAXB)     end_ev(1'b1, 6'h10);
        else if (nbits % 8 != 0)   end_ev(1'b1, 6'h02);
        else if (nfull == 0)       end_ev(1'b1, 6'h04);
`ifdef M_RECEIVER_CRC8_EN
        else if (crc != 8'h00)     end_ev(1'b1, 6'h20);
`endif
        else                       end_ev(1'b0, 6'h00);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        rx = ~b;
        wait_cyc(B / 2);
        rx = b;
        last_mid_t = $time;
        if (glitch) begin
            wait_cyc(2);
            rx = ~b;
            wait_cyc(1);
            rx = b;
            wait_cyc(B / 2 - 3);
        end else begin
            wait_cyc(B / 2);
        end
    endtask

    task automatic send_head(input int npre);
        logic [7:0] sfd;
        sfd = 8'hD5;
        for (int i = 0; i < npre; i++) send_bit((i % 2) == 0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sfd[i], 1'b0);
    endtask

    task automatic send_frame(input int npre, input int nbits, input int g);
        logic [7:0] cur;
        model_frame(npre, nbits, g);
        send_head(npre);
        for (int i = 0; i < nbits; i++) begin
            cur = fb[i / 8];
            send_bit(cur[i % 8], i == g);
        end
        rx = 1'b0;
        wait_cyc(64);
        check("busy_after_idle", {31'd0, o_busy}, 0);
    endtask

    // Monitor: pops and compares whenever the receiver presents a strobe.
    initial begin
        ev_t        ev;
        logic       end_pend;
        logic [5:0] pend_sticky;
        logic [7:0] pend_count;
        end_pend = 1'b0;
        pend_sticky = 6'd0;
        pend_count = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                end_pend = 1'b0;
            end else begin
                if (end_pend) begin
                    check("frames_count", {24'd0, o_frames_count}, {24'd0, pend_count});
                    check("status_after_end", {24'd0, o_status}, {26'd0, pend_sticky});
                    end_pend = 1'b0;
                end
                if (o_frame_start) begin
                    check("start_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        check("start_kind", ev.kind, EV_START);
                    end
                end
                if (o_data_valid) begin
                    check("data_expected", 32'(exp_q.size() != 0), 1);
                    check("data_latency", 32'($time - last_mid_t), 3 * T);
                    check("data_in_frame", {30'd0, o_status[7:6]}, 2'b01);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        check("data_kind", ev.kind, EV_DATA);
                        check("data_value", {24'd0, o_data}, {24'd0, ev.data});
                    end
                end
                if (o_frame_end) begin
                    check("end_expected", 32'(exp_q.size() != 0), 1);
                    check("end_valid_overlap", {31'd0, o_data_valid}, 0);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        check("end_kind", ev.kind, EV_END);
                        check("end_err", {31'd0, o_frame_err}, {31'd0, ev.err});
                        end_pend    = 1'b1;
                        pend_sticky = ev.sticky;
                        pend_count  = ev.count;
                    end
                end
            end
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         len;
        logic [7:0] crc;
        logic [7:0] cur;
        rst_n = 1'b0;
        rx    = 1'b0;
        wait_cyc(3);
        check("rst_data", {24'd0, o_data}, 0);
        check("rst_strobes", {28'd0, o_data_valid, o_frame_start, o_frame_end, o_frame_err}, 0);
        check("rst_count", {24'd0, o_frames_count}, 0);
        check("rst_status_busy", {23'd0, o_status, o_busy}, 0);
        rst_n = 1'b1;
        wait_cyc(8);

        fb = {8'h3C, 8'hA5};
        send_frame(32, 16, -1);

        fb = {8'h3C};
        send_frame(8, 8, -1);
        check("short_pre_count", {24'd0, o_frames_count}, exp_count);

        fb = {8'h3C, 8'h5A};
        send_frame(32, 12, -1);

        fb = {8'h3C, 8'hA5};
        send_frame(32, 16, 11);
        fb = {8'h66, 8'h99};
        send_frame(32, 16, -1);

        // Reset in the middle of a byte: only the frame start may have been seen.
        fb = {8'h3C};
        push_ev(EV_START, 8'h00, 1'b0);
        send_head(20);
        cur = fb[0];
        for (int i = 0; i < 4; i++) send_bit(cur[i], 1'b0);
        rx    = 1'b0;
        rst_n = 1'b0;
        wait_cyc(2);
        check("midrst_outputs", {o_data, o_frames_count, o_status, 4'd0, o_busy, o_data_valid, o_frame_end, o_frame_err}, 0);
        check("midrst_queue", exp_q.size(), 0);
        exp_count  = 0;
        exp_sticky = 6'd0;
        exp_last   = 8'h00;
        rst_n = 1'b1;
        wait_cyc(16);
        fb = {8'h12};
        send_frame(20, 8, -1);
        check("postrst_data", {24'd0, o_data}, 32'h12);

`ifdef M_RECEIVER_CRC8_EN
        fb = {8'h01, 8'h07};
        send_frame(24, 16, -1);
        fb = {8'h01, 8'h08};
        send_frame(24, 16, -1);
`endif

        for (int f = 0; f < 10; f++) begin
            len = int'($urandom_range(1, 5));
            fb  = {};
            crc = 8'h00;
            for (int i = 0; i < len; i++) begin
                cur = 8'($urandom);
                fb.push_back(cur);
                crc = crc8(crc, cur);
            end
`ifdef M_RECEIVER_CRC8_EN
            fb.push_back(crc);
`endif
            send_frame(2 * int'($urandom_range(5, 20)), 8 * fb.size(), -1);
        end

        fb = {};
        for (int i = 0; i < MAXB + 1; i++) fb.push_back(8'($urandom));
        send_frame(16, 8 * (MAXB + 1), -1);
        check("overflow_hold_data", {24'd0, o_data}, {24'd0, exp_last});

        wait_cyc(4);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
